// File: rtl/dir_command_gen_pkg.sv
// Shared direction codes and FSM encodings for the pushbutton command path and grid tracker.
package dir_command_gen_pkg;

  localparam int unsigned KEY_W = 4;
  localparam int unsigned DIR_W = 3;

  typedef enum logic [DIR_W-1:0] {
    DIR_IDLE  = 3'b000,
    DIR_UP    = 3'b001,
    DIR_DOWN  = 3'b010,
    DIR_RIGHT = 3'b011,
    DIR_LEFT  = 3'b100
  } dir_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_HOLD = 2'b10
  } cmd_state_e;

  function automatic logic is_onehot(input logic [KEY_W-1:0] k);
    return (k != '0) && ((k & (k - KEY_W'(1))) == '0);
  endfunction

  // Bit order matches key_n: [0]=Up, [1]=Down, [2]=Right, [3]=Left.
  function automatic dir_code_e key_code(input logic [KEY_W-1:0] k);
    dir_code_e c;
    c = DIR_IDLE;
    if (k[0])      c = DIR_UP;
    else if (k[1]) c = DIR_DOWN;
    else if (k[2]) c = DIR_RIGHT;
    else if (k[3]) c = DIR_LEFT;
    return c;
  endfunction

endpackage

// File: rtl/dir_command_gen_key_debounce.sv
// Two-flop synchroniser plus stability counter for one active-low pushbutton.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_act_c;

  assign sync_act_c = ~sync_q[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], key_n};
      // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
      if (sync_act_c == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level <= sync_act_c;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dir_command_gen.sv
// Turns four debounced pushbuttons into single-cycle direction commands with optional auto-repeat.
module dir_command_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_CYCLES   = 0,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] key_n,
  output logic [2:0] dir,
  output logic       dir_valid,
  output logic [3:0] pressed
);

  import dir_command_gen_pkg::*;

  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  cmd_state_e       state_q;
  logic [3:0]       held_q;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] rep_cnt_q;
  logic             one_hot_c;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_key_debounce (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (key_n[i]),
      .level  (pressed[i])
    );
  end

  assign one_hot_c = is_onehot(pressed);

  // held_q remembers the button that issued the last command; only that button may repeat.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      dir       <= DIR_IDLE;
      dir_valid <= 1'b0;
      held_q    <= '0;
      prev_q    <= '0;
      rep_cnt_q <= '0;
    end else begin
      dir       <= DIR_IDLE;
      dir_valid <= 1'b0;
      prev_q    <= pressed;
      case (state_q)
        ST_IDLE: begin
          rep_cnt_q <= '0;
          if (one_hot_c) begin
            state_q   <= ST_EMIT;
            dir       <= key_code(pressed);
            dir_valid <= 1'b1;
            held_q    <= pressed;
          end else if (pressed != '0) begin
            state_q <= ST_HOLD;
            held_q  <= '0;
          end
        end
        ST_EMIT: begin
          state_q   <= ST_HOLD;
          rep_cnt_q <= '0;
        end
        ST_HOLD: begin
          if (pressed == '0) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
          end else if (REPEAT_CYCLES == 0 || pressed != held_q || pressed != prev_q) begin
            rep_cnt_q <= '0;
          end else if (rep_cnt_q == REP_LAST) begin
            state_q   <= ST_EMIT;
            dir       <= key_code(pressed);
            dir_valid <= 1'b1;
            rep_cnt_q <= '0;
          end else begin
            rep_cnt_q <= rep_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dir_command_gen.sv
// Bench for dir_command_gen: press vectors, repeat, reset-mid-command and button-swap sequences.
module tb_dir_command_gen;
  import dir_command_gen_pkg::*;

  typedef struct {
    int         cyc;
    logic [2:0] code;
  } pulse_t;

  typedef struct {
    logic [3:0] key_n;
    int         hold;
    logic [2:0] code;
    logic [3:0] lvl;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] key0, key1;
  logic [2:0] dir0, dir1;
  logic       dv0, dv1;
  logic [3:0] pressed0, pressed1;

  int     cyc = 0;
  int     n_vec = 0;
  int     n_err = 0;
  pulse_t q0[$];
  pulse_t q1[$];
  vec_t   vecs[8];

  dir_command_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(8)) dut0 (
    .clk(clk), .resetn(resetn), .key_n(key0),
    .dir(dir0), .dir_valid(dv0), .pressed(pressed0)
  );

  dir_command_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8), .CNT_W(8)) dut1 (
    .clk(clk), .resetn(resetn), .key_n(key1),
    .dir(dir1), .dir_valid(dv1), .pressed(pressed1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic report(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard for the non-repeating instance.
  always @(negedge clk) begin
    if (dv0 || dir0 != 3'd0) begin
      if (q0.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut0 unexpected pulse: got dir %0d dir_valid %0d at cycle %0d, expected none",
                 dir0, dv0, cyc);
      end else begin
        pulse_t e;
        e = q0.pop_front();
        report("dut0 pulse cycle", cyc, e.cyc);
        report("dut0 pulse code", int'(dir0), int'(e.code));
        report("dut0 dir_valid", int'(dv0), 1);
      end
    end
  end

  // Scoreboard for the auto-repeat instance.
  always @(negedge clk) begin
    if (dv1 || dir1 != 3'd0) begin
      if (q1.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL dut1 unexpected pulse: got dir %0d dir_valid %0d at cycle %0d, expected none",
                 dir1, dv1, cyc);
      end else begin
        pulse_t e;
        e = q1.pop_front();
        report("dut1 pulse cycle", cyc, e.cyc);
        report("dut1 pulse code", int'(dir1), int'(e.code));
        report("dut1 dir_valid", int'(dv1), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d pulses still expected", q0.size() + q1.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    vecs[0] = '{4'b1110, 20, DIR_UP,    4'b0001};
    vecs[1] = '{4'b1101, 12, DIR_DOWN,  4'b0010};
    vecs[2] = '{4'b1011, 12, DIR_RIGHT, 4'b0100};
    vecs[3] = '{4'b0111, 12, DIR_LEFT,  4'b1000};
    vecs[4] = '{4'b1011,  3, DIR_IDLE,  4'b0000};
    vecs[5] = '{4'b1100, 10, DIR_IDLE,  4'b0011};
    vecs[6] = '{4'b0111, 12, DIR_LEFT,  4'b1000};
    vecs[7] = '{4'b0001, 10, DIR_IDLE,  4'b1110};

    resetn = 1'b0;
    key0   = 4'hF;
    key1   = 4'hF;
    repeat (3) @(negedge clk);
    report("reset dir", int'(dir0), 0);
    report("reset dir_valid", int'(dv0), 0);
    report("reset pressed", int'(pressed0), 0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      t0   = cyc;
      key0 = vecs[i].key_n;
      if (vecs[i].code != 3'd0) q0.push_back('{t0 + 7, vecs[i].code});
      wait_until(t0 + vecs[i].hold);
      report($sformatf("vec%0d pressed while held", i), int'(pressed0), int'(vecs[i].lvl));
      key0 = 4'hF;
      t1   = cyc;
      wait_until(t1 + 5);
      report($sformatf("vec%0d pressed before release settles", i), int'(pressed0), int'(vecs[i].lvl));
      wait_until(t1 + 6);
      report($sformatf("vec%0d pressed released", i), int'(pressed0), 0);
      wait_until(t1 + 12);
      report($sformatf("vec%0d pulses outstanding", i), q0.size(), 0);
    end

    // Auto-repeat: Right held 40 cycles gives pulses at +7, +16, +25, +34, +43.
    @(negedge clk);
    t0   = cyc;
    key1 = 4'b1011;
    for (int k = 0; k < 5; k++) q1.push_back('{t0 + 7 + 9 * k, DIR_RIGHT});
    wait_until(t0 + 40);
    key1 = 4'hF;
    wait_until(t0 + 70);
    report("repeat pulses outstanding", q1.size(), 0);
    report("repeat pressed released", int'(pressed1), 0);

    // Reset during the EMIT cycle while Down stays held.
    @(negedge clk);
    t0   = cyc;
    key0 = 4'b1101;
    q0.push_back('{t0 + 7, DIR_DOWN});
    wait_until(t0 + 7);
    #2 resetn = 1'b0;
    #1;
    report("mid-emit reset dir", int'(dir0), 0);
    report("mid-emit reset dir_valid", int'(dv0), 0);
    report("mid-emit reset pressed", int'(pressed0), 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    t1     = cyc;
    q0.push_back('{t1 + 7, DIR_DOWN});
    wait_until(t1 + 12);
    report("post-reset pressed", int'(pressed0), 4'b0010);
    key0 = 4'hF;
    wait_until(t1 + 26);
    report("post-reset pulses outstanding", q0.size(), 0);

    // Swap Left -> Left+Right -> Right without full release: only the Left command.
    @(negedge clk);
    t0   = cyc;
    key0 = 4'b0111;
    q0.push_back('{t0 + 7, DIR_LEFT});
    wait_until(t0 + 15);
    key0 = 4'b0011;
    wait_until(t0 + 30);
    report("swap chord pressed", int'(pressed0), 4'b1100);
    key0 = 4'b1011;
    wait_until(t0 + 45);
    report("swap right-only pressed", int'(pressed0), 4'b0100);
    report("swap pulses outstanding", q0.size(), 0);
    key0 = 4'hF;
    wait_until(t0 + 58);
    t1   = cyc;
    key0 = 4'b1011;
    q0.push_back('{t1 + 7, DIR_RIGHT});
    wait_until(t1 + 12);
    key0 = 4'hF;
    wait_until(t1 + 26);
    report("swap re-press pulses outstanding", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dir_command_gen.md
# dir_command_gen

Generates the 3-bit direction command consumed by the grid-position tracker from four raw board pushbuttons. Synchronises and debounces each button, then issues exactly one single-cycle direction code per press, with optional auto-repeat while a button is held. Sits between the board KEY pins and the tracker's `dir` input; between commands, `dir` holds Idle.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥2.
- `REPEAT_CYCLES`, default 0: held-button re-issue period in cycles; 0 disables auto-repeat.
- `CNT_W`, default 20: counter width; must hold both `DEBOUNCE_CYCLES` and `REPEAT_CYCLES`.
- `clk`  in  1  system clock; one clock; all state on its rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `key_n`  in  4  raw buttons, active-low, asynchronous to `clk`: [0]=Up, [1]=Down, [2]=Right, [3]=Left.
- `dir`  out  3  command: Idle=000, Up=001, Down=010, Right=011, Left=100; registered.
- `dir_valid`  out  1  high for exactly the cycles in which `dir` ≠ Idle.
- `pressed`  out  4  debounced button levels, active-high, same bit order as `key_n`.

## Operation
- Reset values:
  - `dir`=000, `dir_valid`=0, `pressed`=0000.
  - Synchroniser flops = 1 (released); debounce counters = 0; FSM = IDLE.
- Synchroniser: two flops per bit, producing `sync[i]`.
- Debounce, per bit:
  - If `sync[i]` equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES`, the stable level flips and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` never changes `pressed`.
- FSM states: IDLE, EMIT, HOLD.
- IDLE:
  - `pressed` == 0000: stay.
  - Exactly one bit set: go to EMIT and register the matching code into `dir`.
  - Two or more bits set (chord): go to HOLD; no command is issued.
- EMIT: `dir`/`dir_valid` are asserted for this one cycle. Next state is HOLD; `dir` returns to Idle.
- HOLD:
  - `pressed` == 0000: go to IDLE.
  - Repeat counter, only when `REPEAT_CYCLES`>0 and exactly one bit is set: increments each cycle. On reaching `REPEAT_CYCLES`, go to EMIT with that bit's code and clear the counter.
  - The repeat counter clears whenever `pressed` changes.
- Changing from one button to another without a full release never issues a command. A full release is required first.
- Reset asserted mid-operation clears everything immediately, including an in-flight EMIT; `dir` goes to Idle asynchronously.
- A button held through reset is seen as a new press after release. It issues one command after the normal latency.

## Timing
- Define edge 1 as the first rising edge that samples `key_n[i]`=0.
- `sync[i]` goes low at edge 2.
- `pressed[i]` sets at edge `DEBOUNCE_CYCLES`+2, provided the input stays low throughout.
- `dir`/`dir_valid` are asserted after edge `DEBOUNCE_CYCLES`+3, for exactly one cycle.
- Release follows the same path: `pressed[i]` clears `DEBOUNCE_CYCLES`+2 edges after the first sampled 1.
- Auto-repeat:
  - First repeat pulse: `REPEAT_CYCLES`+1 cycles after the initial EMIT.
  - Later pulses: every `REPEAT_CYCLES`+1 cycles.
- Minimum spacing between any two `dir_valid` pulses is 2 cycles. The tracker therefore never sees back-to-back moves.

## Structure
- Shared package holds the direction codes (Idle/Up/Down/Right/Left) and FSM state encodings. The grid tracker imports the same codes.
- Sub-module `key_debounce`: synchroniser plus counter for one bit, parameterised by `DEBOUNCE_CYCLES`/`CNT_W`, instantiated 4×.
- Top level holds the FSM, the repeat counter and the output registers.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `CNT_W`=8 unless stated.
- Up press: hold `key_n`=1110 for 20 cycles, then release. Expect `dir`=001 with `dir_valid`=1 for exactly one cycle, after edge 7; otherwise 000. `pressed`[0] clears 6 edges after release.
- Glitch rejection: pulse `key_n`[2] low for 3 cycles, then high. Expect `pressed` to stay 0000 and no `dir_valid`.
- Chord: drive `key_n`=1100 (Up+Down) for 10 cycles, release, then press Left. Expect no pulse for the chord, then exactly one `dir`=100.
- Auto-repeat (`REPEAT_CYCLES`=8): hold Right for 40 cycles. Expect `dir`=011 pulses separated by 9 cycles, and none after release.
- Reset mid-EMIT: assert `resetn`=0 in the `dir_valid` cycle while Down stays held, then deassert. Expect `dir`=000 immediately, and one `dir`=010 after 7 further edges.
- Button swap: press Left, then press Right before releasing Left, then release Left. Expect only the Left command; no Right command until both are released and Right is pressed again.
